my_design_checker: RTL and testbench
====================================

MY_DESIGN_CHECKER -- requirements
Module: my_design_checker

Interface
REQ-001 Parameter P_SEED, default 16'hACE1: LFSR seed loaded on each start; SHALL be nonzero.
REQ-002 i_Clock  in  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-003 i_Reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 i_Start  in  1  one-cycle start request, sampled in IDLE or DONE only.
REQ-005 i_Length  in  16  number of stimulus vectors, sampled when the start is accepted.
REQ-006 o_DutData  out  1  stimulus data to the design under test (DUT).
REQ-007 o_DutReset  out  1  active-high synchronous reset stimulus to the DUT.
REQ-008 i_DutDataFF  in  4  DUT registered outputs.
REQ-009 i_DutPassthrough, i_DutOp  in  1 each  DUT combinational outputs.
REQ-010 o_Busy, o_Done, o_Pass  out  1 each  status.
REQ-011 o_ErrorCount  out  16  mismatching-cycle count.
REQ-012 o_FirstErrorCycle  out  16  compare index of the first mismatch; 16'hFFFF if none.

Function
REQ-013 FSM states: IDLE, FLUSH, RUN, DRAIN, DONE.
REQ-014 Transitions:
- IDLE/DONE -> FLUSH on i_Start.
- FLUSH -> RUN after 2 cycles, or FLUSH -> DRAIN if the latched length is 0.
- RUN -> DRAIN after exactly the latched length in cycles.
- DRAIN -> DONE after 2 cycles.
REQ-015 On start acceptance, the block SHALL clear o_ErrorCount, set o_FirstErrorCycle to 16'hFFFF, load the LFSR with P_SEED, and clear o_Done and o_Pass.
REQ-016 FLUSH SHALL drive o_DutReset=1 and o_DutData=0.
REQ-017 RUN stimulus, per cycle:
- o_DutData SHALL be LFSR bit 0.
- o_DutReset SHALL be LFSR bit 1.
- LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing once per RUN cycle.
REQ-018 DRAIN, DONE and IDLE SHALL drive o_DutData=0 and o_DutReset=0.
REQ-019 Expected model: 2-deep history of (data, reset, runValid) for the vectors driven 1 and 2 cycles earlier.
REQ-020 Compares in a cycle where the vector 1 cycle earlier was a RUN vector:
- i_DutDataFF[0] SHALL equal d1.
- i_DutDataFF[1] SHALL equal ~d1.
- i_DutDataFF[2] SHALL equal d1 & ~r1.
REQ-021 In a cycle where the vector 2 cycles earlier was a RUN vector, i_DutDataFF[3] SHALL equal d2 & ~r2.
REQ-022 In RUN cycles, i_DutPassthrough SHALL equal o_DutData and i_DutOp SHALL equal ~o_DutData in the same cycle.
REQ-023 Each cycle with at least one failed compare SHALL add exactly 1 to o_ErrorCount, saturating at 16'hFFFF.
REQ-024 Compare index SHALL be 0 at the first RUN cycle and increment each RUN/DRAIN cycle; the first mismatch SHALL latch it into o_FirstErrorCycle.
REQ-025 o_Busy SHALL be 1 in FLUSH, RUN and DRAIN.
REQ-026 o_Done SHALL be 1 in DONE; o_Pass SHALL be 1 in DONE iff o_ErrorCount==0.
REQ-027 i_Start in FLUSH, RUN or DRAIN SHALL be ignored.
REQ-028 Length 65535 SHALL run 65535 vectors with no counter wrap.

Reset
REQ-029 While i_Reset_n=0, the block SHALL hold:
- FSM=IDLE, LFSR=P_SEED, history cleared.
- o_DutData=0, o_DutReset=0.
- o_Busy=0, o_Done=0, o_Pass=0.
- o_ErrorCount=0, o_FirstErrorCycle=16'hFFFF.
REQ-030 Reset asserted mid-run SHALL abort immediately to the REQ-029 values; a new start is required afterwards.

Structure
REQ-031 A shared package SHALL hold:
- FSM state enum.
- LFSR width, tap mask and default seed.
- FLUSH and DRAIN lengths (2).
- Error sentinel 16'hFFFF.
REQ-032 The LFSR SHALL be one sub-module, my_design_checker_lfsr (load, advance, 16-bit state out).

Verification
REQ-033 Correct DUT model, i_Length=100 -> o_Busy for 104 cycles, then o_Done=1, o_Pass=1, o_ErrorCount=0, o_FirstErrorCycle=16'hFFFF.
REQ-034 DUT model with DataFF[3] inverted, i_Length=100 -> o_ErrorCount=100, o_FirstErrorCycle=2, o_Pass=0.
REQ-035 DUT model with Passthrough inverted, i_Length=100 -> o_ErrorCount=100, o_FirstErrorCycle=0.
REQ-036 i_Length=0 -> o_Busy for 4 cycles, then o_Done=1, o_Pass=1, o_ErrorCount=0.
REQ-037 i_Reset_n pulsed low at RUN cycle 10 -> all outputs reach REQ-029 values without a clock edge; a restart with i_Length=5 then passes.
REQ-038 Forced error on every cycle, i_Length=65535 -> o_ErrorCount=16'hFFFF (saturated) and o_FirstErrorCycle=0.

Source files
------------

// File: rtl/my_design_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_design_checker_pkg
//  Description : Shared types and constants for the DUT stimulus/checker block
//  Revision    : 1.0 - initial release
// ============================================================================
package my_design_checker_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FLUSH = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // One driven stimulus vector as remembered by the expected-value model
   typedef struct packed {
      logic data;
      logic rst;
      logic valid;
   } hist_t;

   localparam int          C_LFSR_W        = 16;
   // Right-shifting Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5
   localparam logic [15:0] C_LFSR_TAP_MASK = 16'h002D;
   localparam logic [15:0] C_LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] C_FLUSH_LEN     = 16'd2;
   localparam logic [15:0] C_DRAIN_LEN     = 16'd2;
   localparam logic [15:0] C_ERR_SENTINEL  = 16'hFFFF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/my_design_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_design_checker_if
//  Description : Stimulus/response bus between the checker and the DUT
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_design_checker_if;
   logic       o_DutData;
   logic       o_DutReset;
   logic [3:0] i_DutDataFF;
   logic       i_DutPassthrough;
   logic       i_DutOp;

   // Checker side drives stimulus and observes responses
   modport master (
      output o_DutData, o_DutReset,
      input  i_DutDataFF, i_DutPassthrough, i_DutOp
   );

   // DUT side consumes stimulus and returns responses
   modport slave (
      input  o_DutData, o_DutReset,
      output i_DutDataFF, i_DutPassthrough, i_DutOp
   );
endinterface
`default_nettype wire

// File: rtl/my_design_checker_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : my_design_checker_lfsr
//  Description : 16-bit Fibonacci LFSR with synchronous load and advance
//  Revision    : 1.0 - initial release
// ============================================================================
module my_design_checker_lfsr
   import my_design_checker_pkg::*;
#(
   parameter logic [C_LFSR_W-1:0] P_SEED = C_LFSR_SEED
) (
   input  wire logic                i_Clock,
   input  wire logic                i_Reset_n,
   input  wire logic                i_Load,
   input  wire logic                i_Advance,
   output logic [C_LFSR_W-1:0]      o_State
);
   logic [C_LFSR_W-1:0] state_d;
   logic [C_LFSR_W-1:0] state_q;
   logic                feedback;

   // Load has priority over advance; new bit enters at the top
   always_comb begin
      feedback = ^(state_q & C_LFSR_TAP_MASK);
      state_d  = state_q;
      if (i_Load) begin
         state_d = P_SEED;
      end else if (i_Advance) begin
         state_d = {feedback, state_q[C_LFSR_W-1:1]};
      end
   end

   // State register, reset to the seed
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) state_q <= P_SEED;
      else            state_q <= state_d;
   end

   assign o_State = state_q;
endmodule
`default_nettype wire

// File: rtl/my_design_checker.sv
`default_nettype none
// ============================================================================
//  Module      : my_design_checker
//  Description : Drives LFSR stimulus into a DUT and checks its responses
//                against a two-deep expected-value history
//  Revision    : 1.0 - initial release
// ============================================================================
module my_design_checker
   import my_design_checker_pkg::*;
#(
   parameter logic [15:0] P_SEED = C_LFSR_SEED
) (
   input  wire logic             i_Clock,
   input  wire logic             i_Reset_n,
   input  wire logic             i_Start,
   input  wire logic [15:0]      i_Length,
   my_design_checker_if.master   dut_if,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Pass,
   output logic [15:0]           o_ErrorCount,
   output logic [15:0]           o_FirstErrorCycle
);
   state_e        state_d, state_q;
   logic [15:0]   cnt_d, cnt_q;        // cycles left in current phase, minus one
   logic [15:0]   len_d, len_q;
   logic [15:0]   idx_d, idx_q;        // compare index
   logic [15:0]   err_d, err_q;
   logic [15:0]   first_d, first_q;
   hist_t         hist1_d, hist1_q;
   hist_t         hist2_d, hist2_q;
   logic          start_ok;
   logic          lfsr_adv;
   logic [15:0]   lfsr_state;
   logic          dut_data;
   logic          dut_rst;
   logic          mismatch;

   my_design_checker_lfsr #(.P_SEED(P_SEED)) u_lfsr (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Load    (start_ok),
      .i_Advance (lfsr_adv),
      .o_State   (lfsr_state)
   );

   // Phase sequencing: each phase loads its length minus one and counts down
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      start_ok = 1'b0;
      lfsr_adv = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_Start) begin
               start_ok = 1'b1;
               state_d  = S_FLUSH;
               cnt_d    = C_FLUSH_LEN - 16'd1;
               len_d    = i_Length;
            end
         end
         S_FLUSH: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (len_q == 16'd0) begin
               state_d = S_DRAIN;
               cnt_d   = C_DRAIN_LEN - 16'd1;
            end else begin
               state_d = S_RUN;
               cnt_d   = len_q - 16'd1;
            end
         end
         S_RUN: begin
            lfsr_adv = 1'b1;
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               state_d = S_DRAIN;
               cnt_d   = C_DRAIN_LEN - 16'd1;
            end
         end
         S_DRAIN: begin
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
            else                state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stimulus decode: reset held during flush, LFSR bits while running
   always_comb begin
      dut_data = 1'b0;
      dut_rst  = 1'b0;
      case (state_q)
         S_FLUSH: dut_rst = 1'b1;
         S_RUN: begin
            dut_data = lfsr_state[0];
            dut_rst  = lfsr_state[1];
         end
         default: ;
      endcase
   end

   // Response compare against the vectors driven one and two cycles ago
   always_comb begin
      mismatch = 1'b0;
      if (hist1_q.valid) begin
         mismatch = mismatch
                  | (dut_if.i_DutDataFF[0] != hist1_q.data)
                  | (dut_if.i_DutDataFF[1] != ~hist1_q.data)
                  | (dut_if.i_DutDataFF[2] != (hist1_q.data & ~hist1_q.rst));
      end
      if (hist2_q.valid) begin
         mismatch = mismatch | (dut_if.i_DutDataFF[3] != (hist2_q.data & ~hist2_q.rst));
      end
      if (state_q == S_RUN) begin
         mismatch = mismatch
                  | (dut_if.i_DutPassthrough != dut_data)
                  | (dut_if.i_DutOp != ~dut_data);
      end
   end

   // Error bookkeeping and history shift; a new run clears the results
   always_comb begin
      err_d   = err_q;
      first_d = first_q;
      idx_d   = idx_q;
      hist1_d = '{data: dut_data, rst: dut_rst, valid: (state_q == S_RUN)};
      hist2_d = hist1_q;
      if (start_ok) begin
         err_d   = 16'd0;
         first_d = C_ERR_SENTINEL;
         idx_d   = 16'd0;
      end else begin
         if (mismatch) begin
            err_d = sat_inc16(err_q);
            if (err_q == 16'd0) first_d = idx_q;
         end
         if (state_q == S_RUN || state_q == S_DRAIN) idx_d = sat_inc16(idx_q);
      end
   end

   // State registers
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         err_q   <= 16'd0;
         first_q <= C_ERR_SENTINEL;
         hist1_q <= '0;
         hist2_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         first_q <= first_d;
         hist1_q <= hist1_d;
         hist2_q <= hist2_d;
      end
   end

   assign dut_if.o_DutData   = dut_data;
   assign dut_if.o_DutReset  = dut_rst;
   assign o_Busy             = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign o_Done             = (state_q == S_DONE);
   assign o_Pass             = (state_q == S_DONE) && (err_q == 16'd0);
   assign o_ErrorCount       = err_q;
   assign o_FirstErrorCycle  = first_q;
endmodule
`default_nettype wire

// File: tb/tb_my_design_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_design_checker
//  Description : Self-checking bench for my_design_checker with a behavioural
//                DUT model that can invert any response bit
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_design_checker;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        start   = 1'b0;
   logic [15:0] length  = 16'd0;
   logic        busy, done, pass_o;
   logic [15:0] err_cnt, first_err;

   my_design_checker_if bus ();

   my_design_checker #(.P_SEED(16'hACE1)) dut (
      .i_Clock           (clk),
      .i_Reset_n         (rst_n),
      .i_Start           (start),
      .i_Length          (length),
      .dut_if            (bus),
      .o_Busy            (busy),
      .o_Done            (done),
      .o_Pass            (pass_o),
      .o_ErrorCount      (err_cnt),
      .o_FirstErrorCycle (first_err)
   );

   always #5 clk = ~clk;

   // Behavioural DUT: bits {ff3,ff2,ff1,ff0,pass,op} of a mask invert outputs
   logic [3:0] model_ff     = 4'd0;
   logic [5:0] persist_mask = 6'd0;
   logic [5:0] glitch_mask  = 6'd0;
   int         glitch_idx   = -100;
   int         tb_idx       = -100;   // compare index of the current cycle
   logic [5:0] cur_mask;

   always @(posedge clk) begin
      model_ff[0] <= bus.o_DutData;
      model_ff[1] <= ~bus.o_DutData;
      model_ff[2] <= bus.o_DutData & ~bus.o_DutReset;
      model_ff[3] <= model_ff[2];
   end

   assign cur_mask             = persist_mask | ((tb_idx == glitch_idx) ? glitch_mask : 6'd0);
   assign bus.i_DutDataFF      = model_ff ^ cur_mask[5:2];
   assign bus.i_DutPassthrough = bus.o_DutData ^ cur_mask[1];
   assign bus.i_DutOp          = ~bus.o_DutData ^ cur_mask[0];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: which compare indices see a faulty bit that is actually compared
   function automatic void model_run(input int n, input logic [5:0] pm, input int gi,
                                     input logic [5:0] gm, output int cnt, output int first);
      cnt   = 0;
      first = 65535;
      for (int k = -2; k <= n + 1; k++) begin
         logic [5:0] m;
         logic       bad;
         m   = pm | ((k == gi) ? gm : 6'd0);
         bad = 1'b0;
         if (k >= 0 && k < n && (m[1] | m[0]))           bad = 1'b1;
         if (k >= 1 && k <= n && (m[4] | m[3] | m[2]))   bad = 1'b1;
         if (k >= 2 && k <= n + 1 && m[5])              bad = 1'b1;
         if (bad) begin
            if (cnt == 0) first = k;
            cnt++;
         end
      end
      if (cnt > 65535) cnt = 65535;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".busy"},  busy,            0);
      check({tag, ".done"},  done,            0);
      check({tag, ".pass"},  pass_o,          0);
      check({tag, ".err"},   err_cnt,         0);
      check({tag, ".first"}, first_err,       65535);
      check({tag, ".data"},  bus.o_DutData,   0);
      check({tag, ".rst"},   bus.o_DutReset,  0);
   endtask

   // One full run from IDLE/DONE to DONE, checking stimulus every cycle
   task automatic do_run(input string name, input int n, input logic [5:0] pm, input int gi,
                         input logic [5:0] gm, input int mid_start,
                         input int exp_cnt, input int exp_first, input int exp_pass);
      logic [15:0] lfsr;
      int          stim_bad;
      logic        exp_d, exp_r;
      lfsr         = 16'hACE1;
      stim_bad     = 0;
      persist_mask = pm;
      glitch_idx   = gi;
      glitch_mask  = gm;
      @(negedge clk);
      start  = 1'b1;
      length = n[15:0];
      tb_idx = -3;
      for (int c = 0; c < n + 4; c++) begin
         @(negedge clk);
         tb_idx = tb_idx + 1;
         start  = (tb_idx == mid_start);
         exp_d  = (tb_idx >= 0 && tb_idx < n) ? lfsr[0] : 1'b0;
         exp_r  = (tb_idx < 0) ? 1'b1 : ((tb_idx < n) ? lfsr[1] : 1'b0);
         if (busy !== 1'b1 || done !== 1'b0 || bus.o_DutData !== exp_d || bus.o_DutReset !== exp_r)
            stim_bad++;
         if (tb_idx >= 0 && tb_idx < n)
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
      @(negedge clk);
      tb_idx = tb_idx + 1;
      start  = 1'b0;
      check({name, ".stim"},  stim_bad,  0);
      check({name, ".busy"},  busy,      0);
      check({name, ".done"},  done,      1);
      check({name, ".pass"},  pass_o,    exp_pass);
      check({name, ".err"},   err_cnt,   exp_cnt);
      check({name, ".first"}, first_err, exp_first);
      glitch_idx = -100;
   endtask

   typedef struct {
      int         n;
      logic [5:0] pm;
      int         gi;
      logic [5:0] gm;
      int         mid;
      int         exp_cnt;
      int         exp_first;
      int         exp_pass;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int mc, mf, n, gi;
      logic [5:0] pm, gm;

      //          n    persist     gidx  gmask      mid   cnt  first  pass
      vecs[0]  = '{100, 6'b000000, -100, 6'b000000, -100,   0, 65535, 1};
      vecs[1]  = '{100, 6'b100000, -100, 6'b000000, -100, 100,     2, 0};
      vecs[2]  = '{100, 6'b000010, -100, 6'b000000,    5, 100,     0, 0};
      vecs[3]  = '{  0, 6'b000000, -100, 6'b000000, -100,   0, 65535, 1};
      vecs[4]  = '{  0, 6'b111111, -100, 6'b000000,   -1,   0, 65535, 1};
      vecs[5]  = '{  1, 6'b100000, -100, 6'b000000, -100,   1,     2, 0};
      vecs[6]  = '{  1, 6'b000001, -100, 6'b000000, -100,   1,     0, 0};
      vecs[7]  = '{  3, 6'b000100, -100, 6'b000000, -100,   3,     1, 0};
      vecs[8]  = '{ 10, 6'b000000,    7, 6'b001000, -100,   1,     7, 0};
      vecs[9]  = '{ 10, 6'b000000,   11, 6'b100000, -100,   1,    11, 0};
      vecs[10] = '{ 10, 6'b000000,   10, 6'b000010, -100,   0, 65535, 1};
      vecs[11] = '{  2, 6'b010000, -100, 6'b000000,    3,   2,     1, 0};

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1 check_idle("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         do_run($sformatf("vec%0d", i), vecs[i].n, vecs[i].pm, vecs[i].gi, vecs[i].gm,
                vecs[i].mid, vecs[i].exp_cnt, vecs[i].exp_first, vecs[i].exp_pass);

      for (int i = 0; i < 12; i++) begin
         n  = int'($urandom_range(0, 40));
         pm = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
         gi = int'($urandom_range(0, n + 3)) - 2;
         gm = 6'($urandom);
         model_run(n, pm, gi, gm, mc, mf);
         do_run($sformatf("rnd%0d", i), n, pm, gi, gm, -100, mc, mf, (mc == 0) ? 1 : 0);
      end

      // Reset pulsed in RUN cycle 10 with errors already counted
      persist_mask = 6'b000010;
      @(negedge clk);
      start  = 1'b1;
      length = 16'd50;
      tb_idx = -3;
      repeat (13) begin
         @(negedge clk);
         tb_idx = tb_idx + 1;
         start  = 1'b0;
      end
      check("midrun.err", err_cnt, 10);
      #2 rst_n = 1'b0;
      #1 check_idle("abort");
      repeat (2) @(negedge clk);
      rst_n        = 1'b1;
      persist_mask = 6'd0;
      tb_idx       = -100;
      @(negedge clk);
      check("abort.stay_idle", busy, 0);
      do_run("restart", 5, 6'd0, -100, 6'd0, -100, 0, 65535, 1);

      // Longest run with every compare cycle failing: count saturates
      do_run("sat", 65535, 6'b000110, -100, 6'd0, -100, 65535, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
